intc_multi: RTL and testbench

- Parametrised interrupt controller that replaces the single I_interrupt wire of the RV32E core with NUM_SRC external sources.
- Per-source enable and per-source level/edge mode; pending tracking with a fixed priority where the lowest index wins.
- Single-level claim/complete handshake.
- Drives one combined request into the core's external-interrupt input. Firmware reaches it through a small word-addressed register port on the data bus.

---
 rtl/intc_multi_pkg.sv | 19 +
 rtl/intc_multi_if.sv | 39 +++
 rtl/intc_multi_prio_enc.sv | 28 ++
 rtl/intc_multi.sv | 181 ++++++++++++++++++
 tb/tb_intc_multi.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intc_multi_pkg.sv
// ---------------------------------------------------------------------------
// intc_pkg
// Shared constants for the multi-source interrupt controller: the
// word-addressed register map seen by firmware on the data bus and the bit
// positions of the status flags inside the CLAIM register.
// ---------------------------------------------------------------------------
package intc_pkg;

  // Register select values carried on I_addr
  localparam logic [1:0] INTC_ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] INTC_ADDR_MODE    = 2'd1;
  localparam logic [1:0] INTC_ADDR_PENDING = 2'd2;
  localparam logic [1:0] INTC_ADDR_CLAIM   = 2'd3;

  // Flag positions inside the CLAIM read word
  localparam int INTC_CLAIM_INSV_BIT  = 31;
  localparam int INTC_CLAIM_EMPTY_BIT = 30;

endpackage

// File: rtl/intc_multi_if.sv
// ---------------------------------------------------------------------------
// intc_multi_if
// Groups the firmware register port and the claim/complete handshake of the
// interrupt controller.
//   I_wen / I_addr / I_wdata : register write strobe, select, data
//   O_rdata                  : combinational read data for I_addr
//   I_claim / I_complete     : handler entry / exit pulses
//   O_claim_valid            : one-cycle claim response pulse
//   O_claim_empty            : response carried no source
//   O_claim_id               : ID granted by the last successful claim
// Modports: master drives the requests (core / bench), slave is the
// controller.
// ---------------------------------------------------------------------------
interface intc_multi_if #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) ();

  logic            I_wen;
  logic [1:0]      I_addr;
  logic [31:0]     I_wdata;
  logic [31:0]     O_rdata;
  logic            I_claim;
  logic            I_complete;
  logic            O_claim_valid;
  logic            O_claim_empty;
  logic [ID_W-1:0] O_claim_id;

  modport master (
    output I_wen, I_addr, I_wdata, I_claim, I_complete,
    input  O_rdata, O_claim_valid, O_claim_empty, O_claim_id
  );

  modport slave (
    input  I_wen, I_addr, I_wdata, I_claim, I_complete,
    output O_rdata, O_claim_valid, O_claim_empty, O_claim_id
  );

endinterface

// File: rtl/intc_multi_prio_enc.sv
// ---------------------------------------------------------------------------
// intc_prio_enc
// Combinational lowest-index-first priority encoder.
//   req_i      : NUM_SRC request vector
//   id_o       : index of the lowest set bit (0 when none set)
//   anyValid_o : at least one request bit is set
// ---------------------------------------------------------------------------
module intc_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [ID_W-1:0]    id_o,
  output logic               anyValid_o
);

  // Scan from the top down so the last hit, i.e. the lowest index, wins
  always_comb begin
    id_o       = '0;
    anyValid_o = |req_i;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intc_multi.sv
// ---------------------------------------------------------------------------
// intc_multi
// Multi-source interrupt controller feeding the single external-interrupt
// input of the RV32E core. Per-source enable and level/edge mode, pending
// tracking, lowest-index-first priority and a single-level claim/complete
// handshake.
//   I_clk  : core clock
//   I_rst  : asynchronous active-low reset
//   I_src  : raw active-high interrupt sources
//   bus    : register port and claim/complete handshake (intc_multi_if.slave)
//   O_irq  : registered request to the core
// Build option: define INTC_SYNC_BYPASS_EN to drop the 2-flop input
// synchroniser when all sources are already synchronous to I_clk
// (rise-to-O_irq latency 2 cycles instead of 4).
// ---------------------------------------------------------------------------
module intc_multi
  import intc_pkg::*;
#(
  parameter int          NUM_SRC    = 8,
  parameter int          ID_W       = $clog2(NUM_SRC),
  parameter logic [31:0] RESET_MODE = 32'h0000_0000
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [NUM_SRC-1:0] I_src,
  intc_multi_if.slave        bus,
  output logic               O_irq
);

  localparam logic [NUM_SRC-1:0] ModeInit = RESET_MODE[NUM_SRC-1:0];

  logic [NUM_SRC-1:0] sSync;
  logic [NUM_SRC-1:0] sPrev_q;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               inService_q, inService_d;
  logic               claimValid_q, claimValid_d;
  logic               claimEmpty_q, claimEmpty_d;
  logic [ID_W-1:0]    claimId_q, claimId_d;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] claimClr;
  logic [NUM_SRC-1:0] toEdge;
  logic [NUM_SRC-1:0] edgeNext;
  logic [ID_W-1:0]    encId;
  logic               encAny;
  logic               inServiceEff;
  logic               unusedWdata;

`ifdef INTC_SYNC_BYPASS_EN
  assign sSync = I_src;
`else
  logic [NUM_SRC-1:0] syncMeta_q;
  logic [NUM_SRC-1:0] syncOut_q;

  // Two-flop synchroniser for sources from other clock domains
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      syncMeta_q <= '0;
      syncOut_q  <= '0;
    end else begin
      syncMeta_q <= I_src;
      syncOut_q  <= syncMeta_q;
    end
  end

  assign sSync = syncOut_q;
`endif

  assign eligible    = pending_q & enable_q;
  assign rise        = sSync & ~sPrev_q;
  assign unusedWdata = ^bus.I_wdata;

  intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req_i      (eligible),
    .id_o       (encId),
    .anyValid_o (encAny)
  );

  // Next-state logic. A complete in the same cycle as a claim is applied
  // first, so the claim is judged against the already-released handler.
  // For edge sources a fresh rising edge beats any clear in the same cycle;
  // level sources simply track the synchronised input, except in the cycle
  // they are switched to edge mode, where the old level is dropped.
  // O_irq uses the next in-service value so it drops on the claim edge.
  always_comb begin
    enable_d     = enable_q;
    mode_d       = mode_q;
    w1c          = '0;
    claimClr     = '0;
    claimValid_d = 1'b0;
    claimEmpty_d = claimEmpty_q;
    claimId_d    = claimId_q;
    inServiceEff = inService_q & ~bus.I_complete;
    inService_d  = inServiceEff;

    if (bus.I_wen) begin
      case (bus.I_addr)
        INTC_ADDR_ENABLE:  enable_d = bus.I_wdata[NUM_SRC-1:0];
        INTC_ADDR_MODE:    mode_d   = bus.I_wdata[NUM_SRC-1:0];
        INTC_ADDR_PENDING: w1c      = bus.I_wdata[NUM_SRC-1:0];
        default:           w1c      = '0;
      endcase
    end

    if (bus.I_claim) begin
      claimValid_d = 1'b1;
      if (inServiceEff) begin
        claimEmpty_d = 1'b1;
      end else if (encAny) begin
        claimEmpty_d = 1'b0;
        claimId_d    = encId;
        inService_d  = 1'b1;
        claimClr     = NUM_SRC'(1) << encId;
      end else begin
        claimEmpty_d = 1'b1;
      end
    end

    toEdge    = mode_d & ~mode_q;
    edgeNext  = (pending_q & ~w1c & ~claimClr) | rise;
    pending_d = (mode_q & edgeNext)
              | (~mode_q & ~toEdge & sSync)
              | (toEdge & rise);

    irq_d = (|eligible) & ~inService_d;
  end

  // State registers
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      sPrev_q      <= '0;
      enable_q     <= '0;
      mode_q       <= ModeInit;
      pending_q    <= '0;
      inService_q  <= 1'b0;
      claimValid_q <= 1'b0;
      claimEmpty_q <= 1'b0;
      claimId_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      sPrev_q      <= sSync;
      enable_q     <= enable_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      inService_q  <= inService_d;
      claimValid_q <= claimValid_d;
      claimEmpty_q <= claimEmpty_d;
      claimId_q    <= claimId_d;
      irq_q        <= irq_d;
    end
  end

  // Read mux; bits above the register width read as zero
  always_comb begin
    bus.O_rdata = '0;
    case (bus.I_addr)
      INTC_ADDR_ENABLE:  bus.O_rdata[NUM_SRC-1:0] = enable_q;
      INTC_ADDR_MODE:    bus.O_rdata[NUM_SRC-1:0] = mode_q;
      INTC_ADDR_PENDING: bus.O_rdata[NUM_SRC-1:0] = pending_q;
      default: begin
        bus.O_rdata[ID_W-1:0]             = claimId_q;
        bus.O_rdata[INTC_CLAIM_INSV_BIT]  = inService_q;
        bus.O_rdata[INTC_CLAIM_EMPTY_BIT] = claimEmpty_q;
      end
    endcase
  end

  assign bus.O_claim_valid = claimValid_q;
  assign bus.O_claim_empty = claimEmpty_q;
  assign bus.O_claim_id    = claimId_q;
  assign O_irq             = irq_q;

endmodule

// File: tb/tb_intc_multi.sv
// ---------------------------------------------------------------------------
// tb_intc_multi
// Self-checking bench for intc_multi: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the
// controller's rules kept in this file.
// ---------------------------------------------------------------------------
module tb_intc_multi;
  import intc_pkg::*;

  localparam int          NumSrc    = 8;
  localparam int          IdW       = $clog2(NumSrc);
  localparam logic [31:0] ResetMode = 32'h0000_0041;
`ifdef INTC_SYNC_BYPASS_EN
  localparam int SyncStages = 0;
`else
  localparam int SyncStages = 2;
`endif
  localparam int ExpLat = SyncStages + 2;

  logic              clock;
  logic              resetN;
  logic [NumSrc-1:0] srcVal;
  logic              irq;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [NumSrc-1:0] mEn, mMode, mPend, mPrev, pipe0, pipe1;
  logic              mInSvc, mValid, mEmpty, mIrq;
  logic [IdW-1:0]    mId;

  intc_multi_if #(.NUM_SRC(NumSrc)) bus ();

  intc_multi #(
    .NUM_SRC    (NumSrc),
    .RESET_MODE (ResetMode)
  ) dut (
    .I_clk (clock),
    .I_rst (resetN),
    .I_src (srcVal),
    .bus   (bus),
    .O_irq (irq)
  );

  always #5 clock = ~clock;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mEn    = '0;
    mMode  = ResetMode[NumSrc-1:0];
    mPend  = '0;
    mPrev  = '0;
    pipe0  = '0;
    pipe1  = '0;
    mInSvc = 1'b0;
    mValid = 1'b0;
    mEmpty = 1'b0;
    mIrq   = 1'b0;
    mId    = '0;
  endtask

  // One clock edge of the controller's rules, from the inputs held over it
  task automatic modelStep();
    logic [NumSrc-1:0] seen, elig, w1c, newEn, newMode, newPend;
    logic              svc, newSvc, newEmpty, rose;
    logic [IdW-1:0]    newId;
    int                granted;
    seen     = (SyncStages == 0) ? srcVal : pipe1;
    elig     = mPend & mEn;
    svc      = mInSvc && !bus.I_complete;
    newSvc   = svc;
    newEmpty = mEmpty;
    newId    = mId;
    granted  = -1;
    if (bus.I_claim) begin
      if (svc) newEmpty = 1'b1;
      else begin
        for (int i = 0; i < NumSrc; i++) if (granted < 0 && elig[i]) granted = i;
        if (granted >= 0) begin
          newId    = IdW'(granted);
          newEmpty = 1'b0;
          newSvc   = 1'b1;
        end else newEmpty = 1'b1;
      end
    end
    newEn   = mEn;
    newMode = mMode;
    w1c     = '0;
    if (bus.I_wen) begin
      if (bus.I_addr == 2'd0) newEn   = bus.I_wdata[NumSrc-1:0];
      if (bus.I_addr == 2'd1) newMode = bus.I_wdata[NumSrc-1:0];
      if (bus.I_addr == 2'd2) w1c     = bus.I_wdata[NumSrc-1:0];
    end
    for (int i = 0; i < NumSrc; i++) begin
      rose = seen[i] && !mPrev[i];
      if (mMode[i])        newPend[i] = (mPend[i] && !w1c[i] && granted != i) || rose;
      else if (newMode[i]) newPend[i] = rose;
      else                 newPend[i] = seen[i];
    end
    mIrq   = (elig != 0) && !newSvc;
    mValid = bus.I_claim;
    mEmpty = newEmpty;
    mId    = newId;
    mInSvc = newSvc;
    mEn    = newEn;
    mMode  = newMode;
    mPend  = newPend;
    mPrev  = seen;
    pipe1  = pipe0;
    pipe0  = srcVal;
  endtask

  function automatic logic [31:0] expRdata(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0:    r[NumSrc-1:0] = mEn;
      2'd1:    r[NumSrc-1:0] = mMode;
      2'd2:    r[NumSrc-1:0] = mPend;
      default: begin
        r[IdW-1:0] = mId;
        r[31]      = mInSvc;
        r[30]      = mEmpty;
      end
    endcase
    return r;
  endfunction

  task automatic compareAll();
    checkOutput("irq",        32'(irq),               32'(mIrq));
    checkOutput("claimValid", 32'(bus.O_claim_valid), 32'(mValid));
    checkOutput("claimEmpty", 32'(bus.O_claim_empty), 32'(mEmpty));
    checkOutput("claimId",    32'(bus.O_claim_id),    32'(mId));
    checkOutput("rdata",      bus.O_rdata,            expRdata(bus.I_addr));
  endtask

  // Drives one cycle of inputs at the falling edge, then steps the model on
  // the rising edge and compares on the next falling edge
  task automatic applyStimulus(input logic [NumSrc-1:0] s, input logic w,
                               input logic [1:0] a, input logic [31:0] d,
                               input logic cl, input logic co);
    srcVal         = s;
    bus.I_wen      = w;
    bus.I_addr     = a;
    bus.I_wdata    = d;
    bus.I_claim    = cl;
    bus.I_complete = co;
    @(posedge clock);
    modelStep();
    @(negedge clock);
    compareAll();
  endtask

  task automatic idle(input int n, input logic [NumSrc-1:0] s, input logic [1:0] a);
    for (int k = 0; k < n; k++) applyStimulus(s, 1'b0, a, 32'h0, 1'b0, 1'b0);
  endtask

  // Asserts reset between clock edges and checks the outputs drop at once
  task automatic asyncReset();
    #2;
    bus.I_wen      = 1'b0;
    bus.I_claim    = 1'b0;
    bus.I_complete = 1'b0;
    bus.I_addr     = INTC_ADDR_MODE;
    resetN         = 1'b0;
    modelReset();
    #1;
    checkOutput("rstIrq",   32'(irq),               32'h0);
    checkOutput("rstValid", 32'(bus.O_claim_valid), 32'h0);
    checkOutput("rstEmpty", 32'(bus.O_claim_empty), 32'h0);
    checkOutput("rstId",    32'(bus.O_claim_id),    32'h0);
    checkOutput("rstMode",  bus.O_rdata,            ResetMode & 32'hFF);
    bus.I_addr = INTC_ADDR_CLAIM;
    #1;
    checkOutput("rstClaimReg", bus.O_rdata, 32'h0);
    bus.I_addr = INTC_ADDR_PENDING;
    #1;
    checkOutput("rstPending", bus.O_rdata, 32'h0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    clock          = 1'b0;
    resetN         = 1'b1;
    srcVal         = '0;
    bus.I_wen      = 1'b0;
    bus.I_addr     = INTC_ADDR_ENABLE;
    bus.I_wdata    = '0;
    bus.I_claim    = 1'b0;
    bus.I_complete = 1'b0;
    modelReset();
    asyncReset();

    // Level source 3: latency from rise to request, then claim it
    $display("[TB] level source latency and claim");
    applyStimulus('0, 1'b1, INTC_ADDR_ENABLE, 32'h0C, 1'b0, 1'b0);
    applyStimulus('0, 1'b1, INTC_ADDR_MODE,   32'h00, 1'b0, 1'b0);
    for (int k = 1; k <= ExpLat; k++) begin
      applyStimulus(8'h08, 1'b0, INTC_ADDR_PENDING, 32'h0, 1'b0, 1'b0);
      if (k < ExpLat) checkOutput("s1IrqEarly", 32'(irq), 32'h0);
      else            checkOutput("s1IrqOnTime", 32'(irq), 32'h1);
    end
    applyStimulus(8'h08, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b1, 1'b0);
    checkOutput("s1Valid", 32'(bus.O_claim_valid), 32'h1);
    checkOutput("s1Id",    32'(bus.O_claim_id),    32'h3);
    checkOutput("s1Empty", 32'(bus.O_claim_empty), 32'h0);
    checkOutput("s1IrqLow", 32'(irq), 32'h0);
    applyStimulus('0, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b0, 1'b1);
    idle(5, '0, INTC_ADDR_PENDING);

    // Edge source 0: pending capture, W1C, and set beating clear
    $display("[TB] edge source set versus W1C");
    applyStimulus('0, 1'b1, INTC_ADDR_MODE,   32'h01, 1'b0, 1'b0);
    applyStimulus('0, 1'b1, INTC_ADDR_ENABLE, 32'h01, 1'b0, 1'b0);
    idle(3, '0, INTC_ADDR_PENDING);
    applyStimulus(8'h01, 1'b0, INTC_ADDR_PENDING, 32'h0, 1'b0, 1'b0);
    idle(4, '0, INTC_ADDR_PENDING);
    checkOutput("s2PendSet", bus.O_rdata, 32'h1);
    applyStimulus('0, 1'b1, INTC_ADDR_PENDING, 32'h1, 1'b0, 1'b0);
    checkOutput("s2PendCleared", bus.O_rdata, 32'h0);
    for (int k = 1; k <= SyncStages + 1; k++)
      applyStimulus((k == 1) ? 8'h01 : 8'h00, (k == SyncStages + 1),
                    INTC_ADDR_PENDING, 32'h1, 1'b0, 1'b0);
    checkOutput("s2SetWins", bus.O_rdata, 32'h1);
    applyStimulus('0, 1'b1, INTC_ADDR_PENDING, 32'h1, 1'b0, 1'b0);

    // Edge sources 5 and 2: priority order across claim/complete
    $display("[TB] priority across claim and complete");
    applyStimulus('0, 1'b1, INTC_ADDR_MODE,   32'h24, 1'b0, 1'b0);
    applyStimulus('0, 1'b1, INTC_ADDR_ENABLE, 32'h24, 1'b0, 1'b0);
    applyStimulus(8'h24, 1'b0, INTC_ADDR_PENDING, 32'h0, 1'b0, 1'b0);
    idle(ExpLat + 1, '0, INTC_ADDR_PENDING);
    checkOutput("s3Pending", bus.O_rdata, 32'h24);
    applyStimulus('0, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b1, 1'b0);
    checkOutput("s3FirstId", 32'(bus.O_claim_id), 32'h2);
    applyStimulus('0, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b1, 1'b0);
    checkOutput("s3SecondId", 32'(bus.O_claim_id), 32'h5);
    applyStimulus('0, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b0, 1'b1);

    // Empty claim, then a claim while already in service
    $display("[TB] empty claims");
    applyStimulus('0, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b1, 1'b0);
    checkOutput("s4Valid", 32'(bus.O_claim_valid), 32'h1);
    checkOutput("s4Empty", 32'(bus.O_claim_empty), 32'h1);
    applyStimulus(8'h04, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b0, 1'b0);
    idle(ExpLat + 1, '0, INTC_ADDR_CLAIM);
    applyStimulus('0, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b1, 1'b0);
    checkOutput("s4Granted", 32'(bus.O_claim_id), 32'h2);
    applyStimulus('0, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b1, 1'b0);
    checkOutput("s4BusyEmpty", 32'(bus.O_claim_empty), 32'h1);
    checkOutput("s4IdHeld",    32'(bus.O_claim_id),    32'h2);

    // Complete and claim together with level source 1 pending
    $display("[TB] complete and claim in one cycle");
    applyStimulus('0, 1'b1, INTC_ADDR_MODE,   32'h20, 1'b0, 1'b0);
    applyStimulus('0, 1'b1, INTC_ADDR_ENABLE, 32'h02, 1'b0, 1'b0);
    idle(ExpLat + 1, 8'h02, INTC_ADDR_CLAIM);
    applyStimulus(8'h02, 1'b0, INTC_ADDR_CLAIM, 32'h0, 1'b1, 1'b1);
    checkOutput("s5Valid", 32'(bus.O_claim_valid), 32'h1);
    checkOutput("s5Id",    32'(bus.O_claim_id),    32'h1);
    checkOutput("s5InSvc", 32'(bus.O_rdata[31]),   32'h1);

    // Reset in the middle of a handler
    $display("[TB] reset while in service");
    asyncReset();

    // Random traffic
    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      logic [NumSrc-1:0] flip;
      flip = NumSrc'($urandom & $urandom & $urandom);
      if (n == 750) asyncReset();
      applyStimulus(srcVal ^ flip, ($urandom_range(0, 3) == 0),
                    2'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
